peripheral_spram_initiator_axi4: RTL

- AXI4 initiator (manager) bridge: converts a simple core-side memory request port (req/we/addr/be/data) into single-beat AXI4 transactions.
- Drives the AXI4 subordinate port of the SPRAM peripheral, or any AXI4 target in the MPSoC fabric.
- One transaction outstanding at a time; completion returned on a one-cycle response strobe.

---
 rtl/peripheral_spram_axi4_pkg.sv | 33 +++
 rtl/peripheral_spram_initiator_axi4.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_spram_axi4_pkg.sv
// +-----------------------------------------------------------------------------
// | Module      : peripheral_spram_axi4_pkg
// | Description : Shared FSM states and AXI4 encodings for the SPRAM initiator.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

package peripheral_spram_axi4_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    ERR     = 3'd5
  } state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [3:0] CACHE_DEFAULT = 4'b0010;
  localparam logic [2:0] PROT_DEFAULT  = 3'b000;

endpackage

`default_nettype wire

// File: rtl/peripheral_spram_initiator_axi4.sv
// +-----------------------------------------------------------------------------
// | Module      : peripheral_spram_initiator_axi4
// | Description : Core req/gnt port to single-beat AXI4 manager bridge.
// |               Optional macro PERIPHERAL_SPRAM_INITIATOR_ALIGN_CHECK_EN
// |               rejects misaligned requests locally with err_o.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module peripheral_spram_initiator_axi4
  import peripheral_spram_axi4_pkg::*;
#(
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_STRB_WIDTH = 8,
  parameter int unsigned AXI_USER_WIDTH = 10,
  parameter int unsigned AXI_ID_VALUE   = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic                      we_i,
  input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
  input  logic [AXI_STRB_WIDTH-1:0] be_i,
  input  logic [AXI_DATA_WIDTH-1:0] data_i,
  output logic                      rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0] data_o,
  output logic                      err_o,
  output logic [AXI_ID_WIDTH-1:0]   axi_aw_id,
  output logic [AXI_ADDR_WIDTH-1:0] axi_aw_addr,
  output logic [7:0]                axi_aw_len,
  output logic [2:0]                axi_aw_size,
  output logic [1:0]                axi_aw_burst,
  output logic                      axi_aw_lock,
  output logic [3:0]                axi_aw_cache,
  output logic [2:0]                axi_aw_prot,
  output logic [3:0]                axi_aw_qos,
  output logic [3:0]                axi_aw_region,
  output logic [AXI_USER_WIDTH-1:0] axi_aw_user,
  output logic                      axi_aw_valid,
  input  logic                      axi_aw_ready,
  output logic [AXI_ID_WIDTH-1:0]   axi_ar_id,
  output logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr,
  output logic [7:0]                axi_ar_len,
  output logic [2:0]                axi_ar_size,
  output logic [1:0]                axi_ar_burst,
  output logic                      axi_ar_lock,
  output logic [3:0]                axi_ar_cache,
  output logic [2:0]                axi_ar_prot,
  output logic [3:0]                axi_ar_qos,
  output logic [3:0]                axi_ar_region,
  output logic [AXI_USER_WIDTH-1:0] axi_ar_user,
  output logic                      axi_ar_valid,
  input  logic                      axi_ar_ready,
  output logic [AXI_DATA_WIDTH-1:0] axi_w_data,
  output logic [AXI_STRB_WIDTH-1:0] axi_w_strb,
  output logic                      axi_w_last,
  output logic [AXI_USER_WIDTH-1:0] axi_w_user,
  output logic                      axi_w_valid,
  input  logic                      axi_w_ready,
  input  logic [AXI_ID_WIDTH-1:0]   axi_r_id,
  input  logic [AXI_DATA_WIDTH-1:0] axi_r_data,
  input  logic [1:0]                axi_r_resp,
  input  logic                      axi_r_last,
  input  logic [AXI_USER_WIDTH-1:0] axi_r_user,
  input  logic                      axi_r_valid,
  output logic                      axi_r_ready,
  input  logic [AXI_ID_WIDTH-1:0]   axi_b_id,
  input  logic [1:0]                axi_b_resp,
  input  logic [AXI_USER_WIDTH-1:0] axi_b_user,
  input  logic                      axi_b_valid,
  output logic                      axi_b_ready
);

  localparam int unsigned OFFS_W  = $clog2(AXI_STRB_WIDTH);
  localparam logic [2:0]  AX_SIZE = 3'(OFFS_W);

  state_e                    r_state;
  state_e                    w_next;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [AXI_STRB_WIDTH-1:0] r_be;
  logic [AXI_DATA_WIDTH-1:0] r_wdata;
  logic                      r_we;
  logic                      r_aw_done;
  logic                      r_w_done;
  logic                      r_rvalid;
  logic                      r_err;
  logic [AXI_DATA_WIDTH-1:0] r_rdata;
  logic                      w_misaligned;
  logic                      w_aw_hs;
  logic                      w_w_hs;
  logic                      w_b_hs;
  logic                      w_r_hs;

`ifdef PERIPHERAL_SPRAM_INITIATOR_ALIGN_CHECK_EN
  assign w_misaligned = |addr_i[OFFS_W-1:0];
`else
  assign w_misaligned = 1'b0;
`endif

  // Handshakes derived from state/flags, not from the valid outputs, to keep
  // the next-state logic free of combinational loops.
  assign w_aw_hs = (r_state == WR_REQ) && !r_aw_done && axi_aw_ready;
  assign w_w_hs  = (r_state == WR_REQ) && !r_w_done  && axi_w_ready;
  assign w_b_hs  = (r_state == WR_RESP) && axi_b_valid;
  assign w_r_hs  = (r_state == RD_RESP) && axi_r_valid;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    gnt_o        = 1'b0;
    axi_aw_valid = 1'b0;
    axi_w_valid  = 1'b0;
    axi_ar_valid = 1'b0;
    axi_b_ready  = 1'b0;
    axi_r_ready  = 1'b0;
    case (r_state)
      IDLE: begin
        gnt_o = req_i;
        if (req_i) w_next = w_misaligned ? ERR : (we_i ? WR_REQ : RD_REQ);
      end
      WR_REQ: begin
        axi_aw_valid = !r_aw_done;
        axi_w_valid  = !r_w_done;
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next = WR_RESP;
      end
      WR_RESP: begin
        axi_b_ready = 1'b1;
        if (axi_b_valid) w_next = IDLE;
      end
      RD_REQ: begin
        axi_ar_valid = 1'b1;
        if (axi_ar_ready) w_next = RD_RESP;
      end
      RD_RESP: begin
        axi_r_ready = 1'b1;
        if (axi_r_valid) w_next = IDLE;
      end
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rvalid <= 1'b0;
      if (r_state == IDLE) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        if (req_i) begin
          r_addr  <= addr_i;
          r_be    <= be_i;
          r_wdata <= data_i;
          r_we    <= we_i;
          // A rejected misaligned request completes in the cycle after grant.
          if (w_misaligned) begin
            r_rvalid <= 1'b1;
            r_err    <= 1'b1;
          end
        end
      end
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
      if (w_b_hs) begin
        r_rvalid <= 1'b1;
        r_err    <= axi_b_resp[1];
      end
      if (w_r_hs) begin
        r_rvalid <= 1'b1;
        r_err    <= axi_r_resp[1];
        r_rdata  <= axi_r_data;
      end
    end
  end

  assign rvalid_o = r_rvalid;
  assign err_o    = r_err;
  assign data_o   = r_rdata;

  assign axi_aw_id     = AXI_ID_WIDTH'(AXI_ID_VALUE);
  assign axi_aw_addr   = r_addr;
  assign axi_aw_len    = 8'd0;
  assign axi_aw_size   = AX_SIZE;
  assign axi_aw_burst  = BURST_INCR;
  assign axi_aw_lock   = 1'b0;
  assign axi_aw_cache  = CACHE_DEFAULT;
  assign axi_aw_prot   = PROT_DEFAULT;
  assign axi_aw_qos    = 4'd0;
  assign axi_aw_region = 4'd0;
  assign axi_aw_user   = '0;

  assign axi_ar_id     = AXI_ID_WIDTH'(AXI_ID_VALUE);
  assign axi_ar_addr   = r_addr;
  assign axi_ar_len    = 8'd0;
  assign axi_ar_size   = AX_SIZE;
  assign axi_ar_burst  = BURST_INCR;
  assign axi_ar_lock   = 1'b0;
  assign axi_ar_cache  = CACHE_DEFAULT;
  assign axi_ar_prot   = PROT_DEFAULT;
  assign axi_ar_qos    = 4'd0;
  assign axi_ar_region = 4'd0;
  assign axi_ar_user   = '0;

  assign axi_w_data = r_wdata;
  assign axi_w_strb = r_be;
  assign axi_w_last = 1'b1;
  assign axi_w_user = '0;

  // Response side-band fields carry no meaning for a single-ID, single-beat manager.
  logic w_unused;
  assign w_unused = ^{axi_r_id, axi_r_last, axi_r_user, axi_r_resp[0],
                      axi_b_id, axi_b_user, axi_b_resp[0], r_we};

endmodule

`default_nettype wire
